// File: rtl/aes_bram_port.sv
// aes_bram_port: services the AES sequencer's level-held word requests against a single-port BRAM (AES_BRAM_STATS_EN adds counters).
// Write/error complete 2 cycles after request, read 2+RD_LATENCY; a request still held after completion stalls in REARM.
module aes_bram_port #(
   parameter int unsigned ADDR_W     = 13,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned RD_LATENCY = 2,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic              aes_clk,
   input  logic              aes_rst_n,
   input  logic              aes_start_read,
   input  logic              aes_start_write,
   input  logic [31:0]       aes_bram_addr,
   input  logic [31:0]       aes_bram_write_data,
   output logic [31:0]       aes_bram_read_data,
   output logic              bram_complete,
   output logic              bram_busy,
   output logic              bram_addr_err,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_din,
   input  logic [31:0]       bram_dout
`ifdef AES_BRAM_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_DONE, S_REARM} state_t;

   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_W);
   localparam logic [2:0]  LAT    = 3'(RD_LATENCY);

   state_t            state, state_nxt;
   logic              rd_q, err_q;
   logic [2:0]        lat_cnt;
   logic              req, accept, addr_bad, rd_done;
   logic [31:0]       offset;
   logic [ADDR_W-1:0] word;
   logic              en_nxt, complete_nxt, busy_nxt;
   logic [3:0]        we_nxt;

   assign req      = aes_start_read | aes_start_write;
   assign accept   = (state == S_IDLE) && req;
   assign addr_bad = (aes_bram_addr[1:0] != 2'b00) ||
                     ({1'b0, aes_bram_addr} < WIN_LO) ||
                     ({1'b0, aes_bram_addr} >= WIN_HI);
   assign offset   = aes_bram_addr - BASE_ADDR;
   assign word     = ADDR_W'(offset >> 2);
   assign rd_done  = (state == S_RD_WAIT) && (lat_cnt == LAT);

   always_ff @(posedge aes_clk) begin
      if (!aes_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Errored transactions still spend their ACCESS cycle (with the BRAM idle) so they complete with write timing.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (req) state_nxt = S_ACCESS;
         S_ACCESS:  state_nxt = (rd_q && !err_q) ? S_RD_WAIT : S_DONE;
         S_RD_WAIT: if (rd_done) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_REARM;
         S_REARM:   if (!req) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      en_nxt       = accept && !addr_bad;
      we_nxt       = (en_nxt && !aes_start_read) ? 4'hF : 4'h0;
      complete_nxt = (state_nxt == S_DONE);
      busy_nxt     = (state_nxt != S_IDLE);
   end

   always_ff @(posedge aes_clk) begin
      if (!aes_rst_n) begin
         aes_bram_read_data <= 32'h0;
         bram_complete      <= 1'b0;
         bram_busy          <= 1'b0;
         bram_addr_err      <= 1'b0;
         bram_en            <= 1'b0;
         bram_we            <= 4'h0;
         bram_addr          <= '0;
         bram_din           <= 32'h0;
         lat_cnt            <= 3'd0;
         rd_q               <= 1'b0;
         err_q              <= 1'b0;
      end else begin
         bram_complete <= complete_nxt;
         bram_busy     <= busy_nxt;
         bram_en       <= en_nxt;
         bram_we       <= we_nxt;
         if (accept) begin
            rd_q  <= aes_start_read;
            err_q <= addr_bad;
            if (addr_bad) begin
               bram_addr_err <= 1'b1;
            end else begin
               bram_addr <= word;
               if (!aes_start_read) bram_din <= aes_bram_write_data;
            end
         end
         if (state == S_ACCESS)                   lat_cnt <= 3'd1;
         else if (state == S_RD_WAIT && !rd_done) lat_cnt <= lat_cnt + 3'd1;
         else                                     lat_cnt <= 3'd0;
         if (state == S_ACCESS && err_q && rd_q) aes_bram_read_data <= ERR_DATA;
         else if (rd_done)                       aes_bram_read_data <= bram_dout;
      end
   end

`ifdef AES_BRAM_STATS_EN
   logic rd_evt, wr_evt;
   assign rd_evt = rd_done;
   assign wr_evt = (state == S_ACCESS) && !rd_q && !err_q;

   always_ff @(posedge aes_clk) begin
      if (!aes_rst_n || stats_clr) begin
         rd_count <= 32'h0;
         wr_count <= 32'h0;
      end else begin
         if (rd_evt && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
         if (wr_evt && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_bram_port.sv
// Bench for aes_bram_port: vector table, burst/hold/reset sequences and random traffic against a word-level model.
// A second instance with BASE_ADDR=32'h1000, ADDR_W=4 exercises the window edges.
module tb_aes_bram_port;

   localparam int L = 2;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   typedef struct {
      bit          sel;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_q;
      int          exp_lat;
      int          exp_ens;
      logic [12:0] exp_baddr;
      logic [3:0]  exp_we;
      bit          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        aes_start_read, aes_start_write;
   logic [31:0] aes_bram_addr, wdata;

   logic        m_srd, m_swr, m_cmp, m_busy, m_err, m_en;
   logic [31:0] m_q, m_din, m_dout;
   logic [3:0]  m_we;
   logic [12:0] m_addr;
   logic        b_srd, b_swr, b_cmp, b_busy, b_err, b_en;
   logic [31:0] b_q, b_din, b_dout;
   logic [3:0]  b_we;
   logic [3:0]  b_addr;

   logic        o_cmp, o_busy, o_err, o_en;
   logic [31:0] o_q, o_din;
   logic [3:0]  o_we;
   logic [12:0] o_addr;

   logic [31:0] mem [0:8191];
   logic [31:0] ref_mem [0:8191];
   logic [31:0] pipe [L];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign m_srd  = aes_start_read & ~sel;
   assign m_swr  = aes_start_write & ~sel;
   assign b_srd  = aes_start_read & sel;
   assign b_swr  = aes_start_write & sel;
   assign b_dout = 32'h0BA5_E000;

   assign o_cmp  = sel ? b_cmp : m_cmp;
   assign o_busy = sel ? b_busy : m_busy;
   assign o_err  = sel ? b_err : m_err;
   assign o_en   = sel ? b_en : m_en;
   assign o_q    = sel ? b_q : m_q;
   assign o_din  = sel ? b_din : m_din;
   assign o_we   = sel ? b_we : m_we;
   assign o_addr = sel ? {9'b0, b_addr} : m_addr;

`ifdef AES_BRAM_STATS_EN
   logic        stats_clr, b_stats_clr;
   logic [31:0] rd_count, wr_count, b_rdc, b_wrc;
   assign b_stats_clr = 1'b0;
`endif

   aes_bram_port #(.ADDR_W(13), .BASE_ADDR(32'h0), .RD_LATENCY(L), .ERR_DATA(ERR)) u_main (
      .aes_clk(clk), .aes_rst_n(rst_n), .aes_start_read(m_srd), .aes_start_write(m_swr),
      .aes_bram_addr(aes_bram_addr), .aes_bram_write_data(wdata), .aes_bram_read_data(m_q),
      .bram_complete(m_cmp), .bram_busy(m_busy), .bram_addr_err(m_err), .bram_en(m_en),
      .bram_we(m_we), .bram_addr(m_addr), .bram_din(m_din), .bram_dout(m_dout)
`ifdef AES_BRAM_STATS_EN
      , .stats_clr(stats_clr), .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   aes_bram_port #(.ADDR_W(4), .BASE_ADDR(32'h1000), .RD_LATENCY(L), .ERR_DATA(ERR)) u_base (
      .aes_clk(clk), .aes_rst_n(rst_n), .aes_start_read(b_srd), .aes_start_write(b_swr),
      .aes_bram_addr(aes_bram_addr), .aes_bram_write_data(wdata), .aes_bram_read_data(b_q),
      .bram_complete(b_cmp), .bram_busy(b_busy), .bram_addr_err(b_err), .bram_en(b_en),
      .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout)
`ifdef AES_BRAM_STATS_EN
      , .stats_clr(b_stats_clr), .rd_count(b_rdc), .wr_count(b_wrc)
`endif
   );

   // Single-port BRAM with L-cycle registered read path.
   always @(posedge clk) begin
      if (m_en) begin
         for (int b = 0; b < 4; b++)
            if (m_we[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
         pipe[0] <= mem[m_addr];
      end else begin
         pipe[0] <= 32'h0BAD_0000;
      end
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign m_dout = pipe[L-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Drive a level request from a negedge, scramble addr/data after latch, drop it after completion.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] q, output int lat, output int ens,
                      output int wes, output logic [12:0] a1, output logic [3:0] we1, output logic hb);
      aes_start_read  = rd;
      aes_start_write = wr;
      aes_bram_addr   = a;
      wdata           = d;
      q = 'x; lat = -1; ens = 0; wes = 0; a1 = 'x; we1 = 'x;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (o_en) ens++;
         if (o_we != 4'h0) wes++;
         if (k == 1) begin
            a1  = o_addr;
            we1 = o_we;
         end
         aes_bram_addr = $urandom;
         wdata         = $urandom;
         if (o_cmp) begin
            lat = k;
            q   = o_q;
            break;
         end
      end
      hb = o_busy;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (o_en) ens++;
         if (o_cmp) ens += 100;
         hb = o_busy;
      end
      aes_start_read  = 1'b0;
      aes_start_write = 1'b0;
      @(negedge clk);
      if (o_en) ens++;
      @(negedge clk);
   endtask

   initial begin
      vec_t        vt[14];
      logic [31:0] q, a, d, eq, last_q;
      int          lat, ens, wes, tot_en, tot_cmp, kind;
      logic [12:0] a1;
      logic [3:0]  we1;
      logic        hb, bad, exp_err, r, w;

      for (int i = 0; i < 8192; i++) begin
         mem[i]     = 32'hCAFE_0000 | 32'(i);
         ref_mem[i] = 32'hCAFE_0000 | 32'(i);
      end
      for (int i = 0; i < L; i++) pipe[i] = 32'h0;

      //         sel rd wr addr          wdata          exp_q          lat    ens baddr    we    err
      vt[0]  = '{0, 1, 0, 32'h14,   32'h0,         32'hCAFE_0005, 2+L,   1, 13'd5,    4'h0, 0};
      vt[1]  = '{0, 0, 1, 32'h40,   32'h1234_5678, 32'hCAFE_0005, 2,     1, 13'd16,   4'hF, 0};
      vt[2]  = '{0, 1, 0, 32'h40,   32'h0,         32'h1234_5678, 2+L,   1, 13'd16,   4'h0, 0};
      vt[3]  = '{0, 1, 1, 32'h20,   32'hBAD0_0BAD, 32'hCAFE_0008, 2+L,   1, 13'd8,    4'h0, 0};
      vt[4]  = '{0, 1, 0, 32'h20,   32'h0,         32'hCAFE_0008, 2+L,   1, 13'd8,    4'h0, 0};
      vt[5]  = '{0, 1, 0, 32'h7FFC, 32'h0,         32'hCAFE_1FFF, 2+L,   1, 13'd8191, 4'h0, 0};
      vt[6]  = '{0, 1, 0, 32'h102,  32'h0,         ERR,           2,     0, 13'd0,    4'h0, 1};
      vt[7]  = '{0, 0, 1, 32'h8000, 32'h5555_5555, ERR,           2,     0, 13'd0,    4'h0, 1};
      vt[8]  = '{0, 1, 0, 32'h24,   32'h0,         32'hCAFE_0009, 2+L,   1, 13'd9,    4'h0, 1};
      vt[9]  = '{1, 1, 0, 32'h1004, 32'h0,         32'h0BA5_E000, 2+L,   1, 13'd1,    4'h0, 0};
      vt[10] = '{1, 1, 0, 32'h103C, 32'h0,         32'h0BA5_E000, 2+L,   1, 13'd15,   4'h0, 0};
      vt[11] = '{1, 1, 0, 32'h1040, 32'h0,         ERR,           2,     0, 13'd0,    4'h0, 1};
      vt[12] = '{1, 0, 1, 32'h0FFC, 32'h7777_7777, ERR,           2,     0, 13'd0,    4'h0, 1};
      vt[13] = '{1, 1, 0, 32'h0FFC, 32'h0,         ERR,           2,     0, 13'd0,    4'h0, 1};

      sel = 1'b0;
      aes_start_read = 1'b0; aes_start_write = 1'b0; aes_bram_addr = 32'h0; wdata = 32'h0;
`ifdef AES_BRAM_STATS_EN
      stats_clr = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_q", o_q, 0);       chk("rst_cmp", o_cmp, 0);  chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);   chk("rst_en", o_en, 0);    chk("rst_we", o_we, 0);
      chk("rst_addr", o_addr, 0); chk("rst_din", o_din, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         sel = vt[i].sel;
         txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, 0, q, lat, ens, wes, a1, we1, hb);
         chk($sformatf("v%0d_q", i), q, vt[i].exp_q);
         chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
         chk($sformatf("v%0d_en", i), ens, vt[i].exp_ens);
         chk($sformatf("v%0d_wecyc", i), wes, (vt[i].exp_we != 4'h0) ? 1 : 0);
         chk($sformatf("v%0d_err", i), o_err, vt[i].exp_err);
         chk($sformatf("v%0d_idle", i), o_busy, 0);
         if (vt[i].exp_ens != 0) begin
            chk($sformatf("v%0d_baddr", i), a1, vt[i].exp_baddr);
            chk($sformatf("v%0d_we", i), we1, vt[i].exp_we);
         end
      end
      sel = 1'b0;
      ref_mem[16] = 32'h1234_5678;
      last_q  = 32'hCAFE_0009;
      exp_err = 1'b1;

      tot_en = 0; tot_cmp = 0;
      for (int i = 0; i < 8; i++) begin
         txn(1, 0, 32'h100 + 32'(4*i), 0, 0, q, lat, ens, wes, a1, we1, hb);
         tot_en += ens;
         if (lat > 0) tot_cmp++;
         chk($sformatf("burst%0d_q", i), q, ref_mem[64+i]);
         last_q = ref_mem[64+i];
      end
      chk("burst_en", tot_en, 8);
      chk("burst_cmp", tot_cmp, 8);

      txn(1, 0, 32'h104, 0, 5, q, lat, ens, wes, a1, we1, hb);
      chk("hold_en", ens, 1);
      chk("hold_busy", hb, 1);
      chk("hold_q", q, ref_mem[65]);
      chk("hold_idle", o_busy, 0);
      last_q = ref_mem[65];

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         r = (kind != 1);
         w = (kind != 0);
         d = $urandom;
         case ($urandom_range(0, 7))
            0:       a = {17'h0, 13'($urandom_range(0, 8191)), 2'b00} | 32'($urandom_range(1, 3));
            1:       a = $urandom_range(32'h8000, 32'hFFFF_FFF0) & 32'hFFFF_FFFC;
            default: a = {17'h0, 13'($urandom_range(0, 8191)), 2'b00};
         endcase
         bad = (a[1:0] != 2'b00) || (a >= 32'h8000);
         eq  = r ? (bad ? ERR : ref_mem[a[14:2]]) : last_q;
         txn(r, w, a, d, 0, q, lat, ens, wes, a1, we1, hb);
         if (w && !r && !bad) ref_mem[a[14:2]] = d;
         if (r) last_q = eq;
         exp_err = exp_err | bad;
         chk($sformatf("rnd%0d_q", n), q, eq);
         chk($sformatf("rnd%0d_lat", n), lat, bad ? 2 : (r ? 2 + L : 2));
         chk($sformatf("rnd%0d_en", n), ens, bad ? 0 : 1);
         chk($sformatf("rnd%0d_err", n), o_err, exp_err);
      end

      aes_start_read = 1'b1;
      aes_bram_addr  = 32'h14;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      aes_start_read = 1'b0;
      @(negedge clk);
      chk("mrst_q", o_q, 0);       chk("mrst_cmp", o_cmp, 0);  chk("mrst_busy", o_busy, 0);
      chk("mrst_err", o_err, 0);   chk("mrst_en", o_en, 0);    chk("mrst_we", o_we, 0);
      chk("mrst_addr", o_addr, 0); chk("mrst_din", o_din, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_nocmp", o_cmp, 0);
      txn(1, 0, 32'h14, 0, 0, q, lat, ens, wes, a1, we1, hb);
      chk("mrst_rd_q", q, ref_mem[5]);
      chk("mrst_rd_lat", lat, 2 + L);
      chk("mrst_rd_err", o_err, 0);

`ifdef AES_BRAM_STATS_EN
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      chk("stats_clr0_rd", rd_count, 0);
      for (int i = 0; i < 3; i++) txn(1, 0, 32'(4*i), 0, 0, q, lat, ens, wes, a1, we1, hb);
      for (int i = 0; i < 2; i++) txn(0, 1, 32'h200 + 32'(4*i), 32'hA5A5_0000, 0, q, lat, ens, wes, a1, we1, hb);
      txn(1, 0, 32'h3, 0, 0, q, lat, ens, wes, a1, we1, hb);
      chk("stats_rd", rd_count, 3);
      chk("stats_wr", wr_count, 2);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      chk("stats_clr_rd", rd_count, 0);
      chk("stats_clr_wr", wr_count, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1);
   end

endmodule
